// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: one shift-add or restoring-divide step
// per cycle, fin pulses for one cycle with the sign-corrected result.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_m,
  input  logic            is_d,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            fin,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              op_div;
  logic [1:0]        op_sel;
  logic              neg_q, neg_r, div0;
  logic [XLEN-1:0]   m_reg;
  logic [XLEN-1:0]   dvd_raw;
  logic [PW-1:0]     p_reg;

  logic              start_c, last_c;
  logic              a_signed_c, b_signed_c, neg_a_c, neg_b_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic [XLEN:0]     mul_sum_c, rem_sh_c;
  logic [XLEN-1:0]   rem_diff_c;
  logic              rem_ge_c;
  logic [PW-1:0]     p_nxt_c, prod_c;
  logic [XLEN-1:0]   quo_c, rem_c, res_c;

  assign start_c = (is_m | is_d) & ~flush;
  assign last_c  = (cnt == CNT_W'(XLEN - 1));

  // Operand signedness: is_d wins over is_m when both are raised
  assign a_signed_c = is_d ? ~funct3[0] : (funct3 != 3'd3);
  assign b_signed_c = is_d ? ~funct3[0] : (funct3 < 3'd2);
  assign neg_a_c    = a_signed_c & src1[XLEN-1];
  assign neg_b_c    = b_signed_c & src2[XLEN-1];
  assign mag_a_c    = neg_a_c ? -src1 : src1;
  assign mag_b_c    = neg_b_c ? -src2 : src2;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_c) state_nxt = RUN;
      RUN: begin
        if (flush)       state_nxt = IDLE;
        else if (last_c) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration: p_reg holds {acc, multiplier} or {remainder, quotient}
  always_comb begin
    mul_sum_c  = {1'b0, p_reg[PW-1:XLEN]} + {1'b0, m_reg & {XLEN{p_reg[0]}}};
    rem_sh_c   = {p_reg[PW-1:XLEN], p_reg[XLEN-1]};
    rem_ge_c   = (rem_sh_c >= {1'b0, m_reg});
    rem_diff_c = rem_sh_c[XLEN-1:0] - m_reg;
    if (op_div)
      p_nxt_c = {(rem_ge_c ? rem_diff_c : rem_sh_c[XLEN-1:0]), p_reg[XLEN-2:0], rem_ge_c};
    else
      p_nxt_c = {mul_sum_c, p_reg[XLEN-1:1]};
  end

  // Sign correction and special-case selection on the final iteration's value
  always_comb begin
    prod_c = neg_q ? -p_nxt_c : p_nxt_c;
    quo_c  = p_nxt_c[XLEN-1:0];
    rem_c  = p_nxt_c[PW-1:XLEN];
    res_c  = '0;
    if (!op_div)
      res_c = (op_sel == 2'd0) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
    else if (div0)
      res_c = op_sel[1] ? dvd_raw : '1;
    else if (op_sel[1])
      res_c = neg_r ? -rem_c : rem_c;
    else
      res_c = neg_q ? -quo_c : quo_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin     <= 1'b0;
      busy    <= 1'b0;
      result  <= '0;
      cnt     <= '0;
      op_div  <= 1'b0;
      op_sel  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      div0    <= 1'b0;
      m_reg   <= '0;
      dvd_raw <= '0;
      p_reg   <= '0;
    end else begin
      fin  <= (state_nxt == DONE);
      busy <= (state_nxt != IDLE);
      if (state == IDLE && start_c) begin
        op_div  <= is_d;
        op_sel  <= funct3[1:0];
        neg_q   <= neg_a_c ^ neg_b_c;
        neg_r   <= neg_a_c;
        div0    <= is_d & (src2 == '0);
        dvd_raw <= src1;
        m_reg   <= is_d ? mag_b_c : mag_a_c;
        p_reg   <= {XLEN'(0), (is_d ? mag_a_c : mag_b_c)};
        cnt     <= '0;
      end else if (state == RUN) begin
        p_reg <= p_nxt_c;
        cnt   <= cnt + CNT_W'(1);
        if (state_nxt == DONE) result <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, flush/reset
// behaviour and randomized ops against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        is_m = 1'b0, is_d = 1'b0, flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] src1 = 32'd0, src2 = 32'd0;
  logic        fin, busy;
  logic [31:0] result;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .is_m(is_m), .is_d(is_d), .funct3(funct3),
    .src1(src1), .src2(src2), .flush(flush),
    .fin(fin), .busy(busy), .result(result)
  );

  // RV32M semantics from 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller is just after a posedge; start is sampled at the next edge (edge 0)
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    int          fin_cyc = 0;
    int          fins    = 0;
    logic        busy_ok = 1'b1;
    logic [31:0] exp     = ref_model(f3, a, b);
    is_m = ~f3[2]; is_d = f3[2]; funct3 = f3; src1 = a; src2 = b;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (fin === 1'b1) begin
        fins++;
        if (fin_cyc == 0) fin_cyc = c;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    check({tag, "_fin_cycle"}, 32'(fin_cyc), 32'd33);
    check({tag, "_fin_count"}, 32'(fins), 32'd1);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_result"}, result, exp);
    @(posedge clk);
    #1;
    is_m = 1'b0; is_d = 1'b0;
    check({tag, "_fin_drop"}, 32'(fin), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int          fins;
    logic [31:0] saved;
    logic [2:0]  f;

    // Reset values while rst is held
    #12;
    check("rst_fin", 32'(fin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    check("mul_7_m3_abs", result, 32'hFFFF_FFEB);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh_min");
    check("mulh_min_abs", result, 32'h4000_0000);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    check("mulhu_max_abs", result, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    check("mulhsu_abs", result, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_abs", result, 32'h8000_0000);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    check("rem_ovf_abs", result, 32'd0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    check("div_m7_2_abs", result, 32'hFFFF_FFFD);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    check("rem_m7_2_abs", result, 32'hFFFF_FFFF);
    do_op(3'd5, 32'd100, 32'd0, "divu_z");
    check("divu_z_abs", result, 32'hFFFF_FFFF);
    do_op(3'd7, 32'd100, 32'd0, "remu_z");
    check("remu_z_abs", result, 32'd100);
    do_op(3'd4, 32'hFFFF_FFFB, 32'd0, "div_z");
    check("div_z_abs", result, 32'hFFFF_FFFF);
    do_op(3'd6, 32'hFFFF_FFFB, 32'd0, "rem_z");
    check("rem_z_abs", result, 32'hFFFF_FFFB);

    // Flush mid-run: no fin, result untouched
    do_op(3'd0, 32'h1234, 32'h10, "pre_flush");
    saved = 32'h0001_2340;
    is_m = 1'b1; funct3 = 3'd0; src1 = 32'd5; src2 = 32'd7;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1; is_m = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_fin", 32'(fin), 32'd0);
    fins = 0;
    repeat (40) begin
      @(negedge clk);
      if (fin === 1'b1) fins++;
    end
    check("flush_no_fin", 32'(fins), 32'd0);
    check("flush_result", result, saved);

    // Start request coinciding with flush is ignored
    @(posedge clk); #1 is_m = 1'b1; flush = 1'b1;
    @(posedge clk); #1 is_m = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("start_flush_busy", 32'(busy), 32'd0);
    fins = 0;
    repeat (40) begin
      @(negedge clk);
      if (fin === 1'b1 || busy === 1'b1) fins++;
    end
    check("start_flush_quiet", 32'(fins), 32'd0);

    // Back-to-back: is_m held through fin, DIVU starts the next cycle
    @(posedge clk); #1;
    do_op(3'd0, 32'd3, 32'd4, "b2b_mul");
    do_op(3'd5, 32'd9, 32'd2, "b2b_divu");
    check("b2b_divu_abs", result, 32'd4);

    // Asynchronous reset mid-run
    is_m = 1'b1; funct3 = 3'd0; src1 = 32'd3; src2 = 32'd5;
    @(posedge clk);
    repeat (19) @(posedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_fin", 32'(fin), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_result", result, 32'd0);
    is_m = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    do_op(3'd7, 32'd9, 32'd2, "remu_9_2");
    check("remu_9_2_abs", result, 32'd1);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      do_op(f, pick(), pick(), $sformatf("rand%0d_f%0d", i, f));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
